// File: rtl/vj_std_dev_pkg.sv
// Shared definitions for the window standard-deviation unit.
//
// Contents:
//   - default widths for the window unit
//   - wsd_state_e : FSM state encoding for window_std_dev_seq
//   - win_n()     : pixel count N of a square window
//   - d_width()   : signed width that holds N*sqsum - sum^2 without overflow
package vj_std_dev_pkg;

  localparam int DEF_WINDOW_SIZE = 24;
  localparam int DEF_II_W        = 18;
  localparam int DEF_SQ_W        = 32;
  localparam int DEF_RES_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_VAR  = 3'd2,
    ST_SQRT = 3'd3,
    ST_DONE = 3'd4
  } wsd_state_e;

  function automatic int win_n(input int window_size);
    return window_size * window_size;
  endfunction

  // One extra bit on top of the larger operand keeps the sign of the difference.
  function automatic int d_width(input int window_size, input int ii_w, input int sq_w);
    int prod_w;
    int sq_sum_w;
    prod_w   = sq_w + $clog2(win_n(window_size));
    sq_sum_w = 2 * ii_w;
    return ((prod_w > sq_sum_w) ? prod_w : sq_sum_w) + 1;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring square root, one result bit per clock, MSB first.
//
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   start          : load radicand, clear remainder/root, begin RES_W iterations
//   radicand       : 2*RES_W-bit unsigned operand, sampled on start
//   root           : floor(sqrt(radicand)); final once the last iteration has run
//   last           : high in the cycle whose clock edge performs the final iteration
module isqrt_seq #(
  parameter int RES_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2*RES_W-1:0] radicand,
  output logic [RES_W-1:0]   root,
  output logic               last
);

  localparam int CNT_W = (RES_W > 1) ? $clog2(RES_W) : 1;
  // The remainder never exceeds 2*root, so RES_W+2 bits are ample.
  localparam int REM_W = RES_W + 2;
  localparam int SH_W  = REM_W + 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RES_W - 1);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [REM_W-1:0]   rem_q;
  logic [RES_W-1:0]   root_q;
  logic [2*RES_W-1:0] rad_q;

  logic [SH_W-1:0]    rem_sh;
  logic [SH_W-1:0]    trial;
  logic               take;
  logic [REM_W-1:0]   rem_next;

  // Bring down the next two radicand bits and try (root<<2)|1 against them.
  assign rem_sh   = {rem_q, rad_q[2*RES_W-1 -: 2]};
  assign trial    = {2'b00, root_q, 2'b01};
  assign take     = (rem_sh >= trial);
  assign rem_next = take ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      rad_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_INIT;
      rem_q  <= '0;
      root_q <= '0;
      rad_q  <= radicand;
    end else if (busy_q) begin
      rem_q  <= rem_next;
      root_q <= {root_q[RES_W-2:0], take};
      rad_q  <= {rad_q[2*RES_W-3:0], 2'b00};
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign root = root_q;
  assign last = busy_q && (cnt_q == '0);

endmodule

// File: rtl/window_std_dev_seq.sv
// Window standard deviation for the Viola-Jones scan path:
//   std_dev = floor(sqrt(N*sum(x^2) - sum(x)^2)),  N = WINDOW_SIZE^2
// computed over IDLE -> SUM -> VAR -> SQRT(RES_W cycles) -> DONE.
//
// Handshake: a corner set transfers on the rising edge where in_valid && in_ready;
// a result transfers on the rising edge where out_valid && out_ready. Producers must
// hold data stable while valid is high and not yet accepted; in_ready is high only in
// IDLE, out_valid only in DONE, so exactly one window is in flight.
//
// Ports:
//   clock, reset_n              : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready         : corner-set handshake
//   ii_tl, ii_tr, ii_bl, ii_br  : integral-image corners (II_W)
//   sq_tl, sq_tr, sq_bl, sq_br  : squared-integral corners (SQ_W)
//   out_valid / out_ready       : result handshake
//   std_dev                     : floor square root of the (clamped) radicand
//   clamped                     : radicand was negative or over-range (saturation build)
//   dbg_state                   : current FSM state
//
// Build option: define WSD_SATURATE_EN to clamp negative radicands to 0 and
// over-range radicands to an all-ones result; otherwise the radicand wraps to
// 2*RES_W bits and clamped is tied 0.
module window_std_dev_seq
  import vj_std_dev_pkg::*;
#(
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int II_W        = DEF_II_W,
  parameter int SQ_W        = DEF_SQ_W,
  parameter int RES_W       = DEF_RES_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [II_W-1:0]  ii_tl,
  input  logic [II_W-1:0]  ii_tr,
  input  logic [II_W-1:0]  ii_bl,
  input  logic [II_W-1:0]  ii_br,
  input  logic [SQ_W-1:0]  sq_tl,
  input  logic [SQ_W-1:0]  sq_tr,
  input  logic [SQ_W-1:0]  sq_bl,
  input  logic [SQ_W-1:0]  sq_br,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] std_dev,
  output logic             clamped,
  output wsd_state_e       dbg_state
);

  localparam int N     = win_n(WINDOW_SIZE);
  localparam int DW    = d_width(WINDOW_SIZE, II_W, SQ_W);
  localparam int RAD_W = 2 * RES_W;

  wsd_state_e state_q, state_d;

  logic [II_W-1:0]  ii_tl_q, ii_tr_q, ii_bl_q, ii_br_q;
  logic [SQ_W-1:0]  sq_tl_q, sq_tr_q, sq_bl_q, sq_br_q;
  logic [II_W-1:0]  sum_q;
  logic [SQ_W-1:0]  sqsum_q;
  logic             sat_hi_q;
  logic             clamped_q;

  logic [DW-1:0]    prod;
  logic [DW-1:0]    sum_sq;
  logic [DW-1:0]    d;
  logic             d_neg;
  logic             d_over;
  logic [RAD_W-1:0] radicand;

  logic             sqrt_start;
  logic             sqrt_last;
  logic [RES_W-1:0] root;

  // d is two's complement in DW bits; both products are non-negative and fit
  // below the sign bit, so the MSB of the difference is its sign.
  assign prod   = DW'(N) * DW'(sqsum_q);
  assign sum_sq = DW'(sum_q) * DW'(sum_q);
  assign d      = prod - sum_sq;

`ifdef WSD_SATURATE_EN
  assign d_neg    = d[DW-1];
  assign d_over   = !d[DW-1] && (|d[DW-2:RAD_W]);
  assign radicand = d_neg ? '0 : d[RAD_W-1:0];
`else
  logic d_unused;
  assign d_unused = ^d[DW-1:RAD_W];
  assign d_neg    = 1'b0;
  assign d_over   = 1'b0;
  assign radicand = d[RAD_W-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    sqrt_start = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SUM;
      end
      ST_SUM:  state_d = ST_VAR;
      ST_VAR: begin
        sqrt_start = 1'b1;
        state_d    = ST_SQRT;
      end
      ST_SQRT: begin
        if (sqrt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ii_tl_q   <= '0;
      ii_tr_q   <= '0;
      ii_bl_q   <= '0;
      ii_br_q   <= '0;
      sq_tl_q   <= '0;
      sq_tr_q   <= '0;
      sq_bl_q   <= '0;
      sq_br_q   <= '0;
      sum_q     <= '0;
      sqsum_q   <= '0;
      sat_hi_q  <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        ii_tl_q <= ii_tl;
        ii_tr_q <= ii_tr;
        ii_bl_q <= ii_bl;
        ii_br_q <= ii_br;
        sq_tl_q <= sq_tl;
        sq_tr_q <= sq_tr;
        sq_bl_q <= sq_bl;
        sq_br_q <= sq_br;
      end
      if (state_q == ST_SUM) begin
        // Modular arithmetic: corner differences are only meaningful mod 2^width.
        sum_q   <= ii_br_q - ii_bl_q + ii_tl_q - ii_tr_q;
        sqsum_q <= sq_br_q - sq_bl_q + sq_tl_q - sq_tr_q;
      end
      if (state_q == ST_VAR) begin
        sat_hi_q  <= d_over;
        clamped_q <= d_neg || d_over;
      end
    end
  end

  // The root still iterates on an over-range radicand so latency never varies;
  // its value is simply overridden at the output.
  isqrt_seq #(
    .RES_W(RES_W)
  ) u_isqrt (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (sqrt_start),
    .radicand (radicand),
    .root     (root),
    .last     (sqrt_last)
  );

  assign std_dev   = sat_hi_q ? {RES_W{1'b1}} : root;
  assign clamped   = clamped_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_window_std_dev_seq.sv
// Directed bench for window_std_dev_seq: table of windows with hand-computed
// results, plus backpressure and reset-abort sequences.
module tb_window_std_dev_seq;
  import vj_std_dev_pkg::*;

  localparam int II_W    = 18;
  localparam int SQ_W    = 32;
  localparam int RES_W   = 16;
  localparam int LAT     = RES_W + 2;
  localparam int MAX_LAT = 100;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic             in_valid;
  logic             in_ready;
  logic [II_W-1:0]  ii_tl, ii_tr, ii_bl, ii_br;
  logic [SQ_W-1:0]  sq_tl, sq_tr, sq_bl, sq_br;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] std_dev;
  logic             clamped;
  wsd_state_e       dbg_state;

  window_std_dev_seq dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ii_tl     (ii_tl),
    .ii_tr     (ii_tr),
    .ii_bl     (ii_bl),
    .ii_br     (ii_br),
    .sq_tl     (sq_tl),
    .sq_tr     (sq_tr),
    .sq_bl     (sq_bl),
    .sq_br     (sq_br),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .std_dev   (std_dev),
    .clamped   (clamped),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [II_W-1:0]  ii_tl, ii_tr, ii_bl, ii_br;
    logic [SQ_W-1:0]  sq_tl, sq_tr, sq_bl, sq_br;
    logic [RES_W-1:0] exp_std;
    logic             exp_clamped;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  logic             exp_c_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic drive_window(input vec_t v);
    ii_tl = v.ii_tl; ii_tr = v.ii_tr; ii_bl = v.ii_bl; ii_br = v.ii_br;
    sq_tl = v.sq_tl; sq_tr = v.sq_tr; sq_bl = v.sq_bl; sq_br = v.sq_br;
    in_valid = 1'b1;
  endtask

  // Returns just after the accept edge with in_valid dropped.
  task automatic send_window(input vec_t v);
    int guard;
    drive_window(v);
    guard = 0;
    while (!in_ready && guard < MAX_LAT) begin
      @(posedge clock); #1;
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!out_valid && lat <= MAX_LAT);
  endtask

  task automatic check_result(input string name, input int lat);
    logic [RES_W-1:0] e_std;
    logic             e_c;
    e_std = exp_q.pop_front();
    e_c   = exp_c_q.pop_front();
    if (lat > MAX_LAT) begin
      check({name, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check({name, "_latency"}, lat, LAT);
      check({name, "_std_dev"}, std_dev, e_std);
      check({name, "_clamped"}, clamped, e_c);
    end
  endtask

  task automatic handoff(input string name);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({name, "_out_valid_after_handoff"}, out_valid, 1'b0);
    check({name, "_in_ready_after_handoff"}, in_ready, 1'b1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_state"}, dbg_state, ST_IDLE);
    check({name, "_in_ready"}, in_ready, 1'b1);
    check({name, "_out_valid"}, out_valid, 1'b0);
    check({name, "_std_dev"}, std_dev, 0);
    check({name, "_clamped"}, clamped, 1'b0);
  endtask

  function automatic vec_t mk(input logic [II_W-1:0] a, b, c, dd,
                              input logic [SQ_W-1:0] e, f, g, h,
                              input logic [RES_W-1:0] s, input logic cl);
    vec_t v;
    v.ii_tl = a; v.ii_tr = b; v.ii_bl = c; v.ii_br = dd;
    v.sq_tl = e; v.sq_tr = f; v.sq_bl = g; v.sq_br = h;
    v.exp_std = s; v.exp_clamped = cl;
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  vec_t vecs[8];

  initial begin
    int lat;
    vec_t uni, half200;

`ifdef WSD_SATURATE_EN
    vecs[2] = mk(0, 0, 0, 73440, 0, 0, 0, 18727200, 16'd65535, 1'b1);
    vecs[3] = mk(0, 0, 0, 1,     0, 0, 0, 0,        16'd0,     1'b1);
    vecs[6] = mk(0, 1, 0, 0,     0, 0, 0, 0,        16'd0,     1'b1);
    vecs[7] = mk(0, 0, 0, 0,     0, 1, 0, 0,        16'd65535, 1'b1);
`else
    vecs[2] = mk(0, 0, 0, 73440, 0, 0, 0, 18727200, 16'd33143, 1'b0);
    vecs[3] = mk(0, 0, 0, 1,     0, 0, 0, 0,        16'd65535, 1'b0);
    vecs[6] = mk(0, 1, 0, 0,     0, 0, 0, 0,        16'd724,   1'b0);
    vecs[7] = mk(0, 0, 0, 0,     0, 1, 0, 0,        16'd65535, 1'b0);
`endif
    vecs[0] = mk(0, 0, 0, 57600, 0, 0, 0, 5760000,  16'd0,     1'b0);
    vecs[1] = mk(0, 0, 0, 57600, 0, 0, 0, 11520000, 16'd57600, 1'b0);
    vecs[4] = mk(5, 3, 4, 4,     7, 2, 10, 6,       16'd23,    1'b0);
    vecs[5] = mk(0, 0, 0, 0,     50, 0, 0, 50,      16'd240,   1'b0);
    uni     = vecs[0];
    half200 = vecs[1];

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ii_tl = '0; ii_tr = '0; ii_bl = '0; ii_br = '0;
    sq_tl = '0; sq_tr = '0; sq_bl = '0; sq_br = '0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("after_reset");

    // Table-driven windows
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_std);
      exp_c_q.push_back(vecs[i].exp_clamped);
      send_window(vecs[i]);
      wait_result(lat);
      check_result($sformatf("vec%0d", i), lat);
      handoff($sformatf("vec%0d", i));
    end

    // Backpressure: result held, next window waits for the hand-off
    exp_q.push_back(half200.exp_std);
    exp_c_q.push_back(half200.exp_clamped);
    send_window(half200);
    wait_result(lat);
    check_result("bp_first", lat);
    drive_window(uni);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      check($sformatf("bp_hold%0d_std_dev", c), std_dev, 16'd57600);
      check($sformatf("bp_hold%0d_out_valid", c), out_valid, 1'b1);
      check($sformatf("bp_hold%0d_in_ready", c), in_ready, 1'b0);
    end
    handoff("bp");
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", in_ready, 1'b0);
    exp_q.push_back(uni.exp_std);
    exp_c_q.push_back(uni.exp_clamped);
    wait_result(lat);
    check_result("bp_second", lat);
    handoff("bp_second");

    // Reset abort during SQRT: edges SUM, VAR, then 4 SQRT iterations
    send_window(half200);
    repeat (6) @(posedge clock);
    #1;
    check("abort_pre_state", dbg_state, ST_SQRT);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    exp_q.push_back(uni.exp_std);
    exp_c_q.push_back(uni.exp_clamped);
    send_window(uni);
    wait_result(lat);
    check_result("abort_next", lat);
    handoff("abort_next");

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_std_dev_seq.md
# window_std_dev_seq

Sequential, parametrised window standard-deviation unit for the Viola-Jones scan path. It takes the four corner values of the integral image and squared integral image for one scan window. It returns floor(sqrt(N·Σx² − (Σx)²)), where N = WINDOW_SIZE², which is the normalisation term the classifier stages use. It replaces the single-cycle combinational version with a valid/ready-handshaked, multi-cycle datapath whose iterative square root fits timing at the scan clock.

## Interface
- WINDOW_SIZE, 24, window edge in pixels; N = WINDOW_SIZE² (576 at default)
- II_W, 18, integral-image entry width
- SQ_W, 32, squared-integral-image entry width
- RES_W, 16, result width; the radicand is 2·RES_W bits
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  corner set valid
- in_ready  out  1  block can accept a corner set
- ii_tl, ii_tr, ii_bl, ii_br  in  II_W each  integral-image corners
- sq_tl, sq_tr, sq_bl, sq_br  in  SQ_W each  squared-integral corners
- out_valid  out  1  std_dev valid
- out_ready  in  1  consumer accepts result
- std_dev  out  RES_W  floor square root of the clamped radicand
- clamped  out  1  radicand was negative or over-range (only meaningful with WSD_SATURATE_EN; tied 0 otherwise)

## Operation
- FSM states: IDLE, SUM, VAR, SQRT, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: register all eight corners and go to SUM.
- **SUM**
  - sum = ii_br − ii_bl + ii_tl − ii_tr, computed mod 2^II_W.
  - sqsum = sq_br − sq_bl + sq_tl − sq_tr, computed mod 2^SQ_W.
  - Both results are registered; go to VAR.
- **VAR**
  - Compute d = N·sqsum − sum² at full signed width: max(SQ_W+clog2(N), 2·II_W)+1 bits.
  - Load the radicand (2·RES_W bits), per Configuration.
  - Clear the remainder and root; load the iteration counter with RES_W−1; go to SQRT.
- **SQRT**
  - Restoring digit-by-digit square root, one result bit per cycle, MSB first.
  - Each cycle: shift two radicand bits into the remainder. Trial value = (root<<2)|1. If remainder ≥ trial, subtract it and set the root LSB.
  - When the counter reaches 0, go to DONE.
- **DONE**
  - out_valid=1; std_dev and clamped are held stable.
  - On out_ready, go to IDLE.
- in_ready is asserted only in IDLE, with no bypass from DONE. One window is in flight at a time.
- Reset while busy aborts the computation; no partial result is emitted.

## Timing
- Accept happens on the edge where in_valid && in_ready.
- out_valid rises RES_W+2 edges later: 18 at default.
- The result stays held for any number of out_ready-low cycles.
- Hand-off: out_valid falls on the edge where out_ready is sampled. in_ready rises in the following cycle.
- Minimum issue interval is RES_W+4 cycles.
- Values while reset_n is low and after release:
  - State is IDLE.
  - in_ready=1.
  - out_valid=0.
  - std_dev=0.
  - clamped=0.
  - Iteration counter, remainder and root are all 0.
- in_valid or out_ready asserted in a state that does not sample it is ignored.

## Configuration
- Macro: WSD_SATURATE_EN.
- **Defined**
  - If d < 0, the radicand is 0 and clamped=1.
  - If d ≥ 2^(2·RES_W), the radicand is ignored, std_dev is forced to 2^RES_W−1, and clamped=1.
  - The SQRT state still runs its full RES_W cycles, so latency is unchanged.
- **Undefined**
  - The radicand is d[2·RES_W−1:0] (wrap, legacy behaviour).
  - clamped is tied 0.

## Structure
- Package vj_std_dev_pkg holds:
  - the FSM state enum;
  - localparam functions for N and the d width;
  - the default widths.
- Sub-module isqrt_seq holds the SQRT iteration:
  - start/done interface;
  - 2·RES_W-bit radicand in, RES_W-bit root out;
  - counter, remainder and root registers.
- The top module owns the handshake, sum/variance datapath and clamp logic.

## Test plan
- Uniform window, all pixels 100:
  - Inputs: ii_br=57600, sq_br=5760000, other corners 0.
  - Required: std_dev=0, out_valid 18 cycles after accept, clamped=0.
- Half pixels 0, half 200:
  - Inputs: ii_br=57600, sq_br=11520000.
  - Required: std_dev=57600 in both configurations.
- Half pixels 0, half 255:
  - Inputs: ii_br=73440, sq_br=18727200.
  - Required with macro: std_dev=65535, clamped=1.
  - Required without macro: std_dev=33143.
- Inconsistent corners:
  - Inputs: ii_br=1, sq_br=0.
  - Required with macro: std_dev=0, clamped=1.
  - Required without macro: std_dev=65535.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; keep in_valid=1 with new data.
  - Required: std_dev stable, in_ready=0 throughout. Second window accepted only in the cycle after the hand-off.
- Reset abort:
  - Stimulus: pulse reset_n low in SQRT cycle 5, then accept a uniform window.
  - Required: out_valid=0 and in_ready=1 immediately after the pulse. Next result is 0 after exactly 18 cycles.
